// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state encodings, the
// AXI response code that means success, and the reset-level and boot-address constants.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2,
    StErr  = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  RespOkay       = 2'b00;
  localparam logic [31:0] ResetPcDefault = 32'h8000_0000;
  localparam logic        RstEnable      = 1'b0;

endpackage

// File: rtl/fetch_ctrl.sv
// AXI-lite instruction fetch controller: issues one read per instruction into the IF/ID
// register, handles decode back-pressure, redirects (with kill of in-flight reads) and errors.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  output logic        arvalid_o,
  output logic [31:0] araddr_o,
  input  logic        arready_i,
  input  logic        rvalid_i,
  input  logic [1:0]  rresp_i,
  output logic        rready_o,
  output logic        we_o,
  output logic [31:0] pc_o,
  output logic        idu_valid_o,
  input  logic        idu_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_err_o
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_ar_addr;
  logic         r_kill, w_kill_nxt;
  logic         r_idu_valid, w_idu_valid_nxt;
  logic         w_slot_free, w_r_hs, w_accept, w_load_addr;

  assign w_slot_free = !r_idu_valid || idu_ready_i;
  assign arvalid_o   = (r_state == StAr);
  assign rready_o    = (r_state == StR) && (w_slot_free || r_kill);
  assign w_r_hs      = rvalid_i && rready_o;
  // An accepted response is one that is neither pending-discard nor superseded this cycle.
  assign w_accept    = w_r_hs && !r_kill && !redirect_i;
  assign we_o        = w_accept && (rresp_i == RespOkay);
  assign fetch_err_o = w_accept && (rresp_i != RespOkay);

  assign araddr_o    = r_ar_addr;
  assign pc_o        = r_ar_addr;
  assign idu_valid_o = r_idu_valid;

  always_comb begin
    w_pc_nxt = r_pc;
    if (redirect_i) begin
      w_pc_nxt = redirect_pc_i;
    end else if (we_o) begin
      w_pc_nxt = r_pc + 32'd4;
    end
  end

  always_comb begin
    w_idu_valid_nxt = r_idu_valid;
    if (redirect_i) begin
      w_idu_valid_nxt = 1'b0;
    end else if (we_o) begin
      w_idu_valid_nxt = 1'b1;
    end else if (idu_ready_i) begin
      w_idu_valid_nxt = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    unique case (r_state)
      StIdle: w_state_nxt = StAr;
      StAr: begin
        // The address already on the bus must stay put, so a redirect marks the read as stale.
        if (redirect_i) w_kill_nxt = 1'b1;
        if (arready_i)  w_state_nxt = StR;
      end
      StR: begin
        if (w_r_hs) begin
          w_kill_nxt  = 1'b0;
          w_state_nxt = fetch_err_o ? StErr : StAr;
        end else if (redirect_i) begin
          w_kill_nxt = 1'b1;
        end
      end
      StErr: begin
        if (redirect_i) w_state_nxt = StAr;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // The bus address is captured only when a new read is about to be offered.
  assign w_load_addr = (w_state_nxt == StAr) && (r_state != StAr);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_ar_addr   <= RESET_PC;
      r_kill      <= 1'b0;
      r_idu_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_kill      <= w_kill_nxt;
      r_idu_valid <= w_idu_valid_nxt;
      if (w_load_addr) r_ar_addr <= w_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random bus/decode/redirect traffic,
// each cycle compared against a transaction-level model of the fetch unit.
module tb_fetch_ctrl;

  localparam logic [31:0] ResetPc = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid_o, arready_i, rvalid_i, rready_o, we_o;
  logic        idu_valid_o, idu_ready_i, redirect_i, fetch_err_o;
  logic [31:0] araddr_o, pc_o, redirect_pc_i;
  logic [1:0]  rresp_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model: what the fetch unit is doing, as independent flags.
  bit          m_boot, m_offer, m_wait, m_halt, m_drop, m_live;
  logic [31:0] m_pc, m_addr;

  fetch_ctrl #(.RESET_PC(ResetPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .arvalid_o    (arvalid_o),
    .araddr_o     (araddr_o),
    .arready_i    (arready_i),
    .rvalid_i     (rvalid_i),
    .rresp_i      (rresp_i),
    .rready_o     (rready_o),
    .we_o         (we_o),
    .pc_o         (pc_o),
    .idu_valid_o  (idu_valid_o),
    .idu_ready_i  (idu_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .fetch_err_o  (fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_offer = 1'b0;
    m_wait  = 1'b0;
    m_halt  = 1'b0;
    m_drop  = 1'b0;
    m_live  = 1'b0;
    m_pc    = ResetPc;
    m_addr  = ResetPc;
  endtask

  // Assert reset asynchronously mid-cycle, check the reset outputs, release before the next
  // falling edge so the following step sees the first post-reset cycle.
  task automatic do_reset(input logic stale_rvalid);
    @(negedge clk);
    #2 rst = 1'b0;
    arready_i = 1'b0; rvalid_i = stale_rvalid; rresp_i = 2'b00;
    idu_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    #1;
    chk("rst_arvalid", 32'(arvalid_o), 32'd0);
    chk("rst_rready", 32'(rready_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_idu_valid", 32'(idu_valid_o), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err_o), 32'd0);
    chk("rst_araddr", araddr_o, ResetPc);
    chk("rst_pc", pc_o, ResetPc);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic ar, input logic rv, input logic [1:0] rr, input logic ir,
                      input logic rd, input logic [31:0] rpc);
    logic        e_rready, e_hs, e_we, e_err, e_live;
    logic [31:0] e_pc;
    @(negedge clk);
    arready_i = ar; rvalid_i = rv; rresp_i = rr;
    idu_ready_i = ir; redirect_i = rd; redirect_pc_i = rpc;
    #1;
    e_rready = m_wait && (!m_live || ir || m_drop);
    e_hs     = e_rready && rv;
    e_we     = e_hs && !m_drop && !rd && (rr == 2'b00);
    e_err    = e_hs && !m_drop && !rd && (rr != 2'b00);
    chk("arvalid", 32'(arvalid_o), 32'(m_offer));
    chk("araddr", araddr_o, m_addr);
    chk("pc", pc_o, m_addr);
    chk("rready", 32'(rready_o), 32'(e_rready));
    chk("we", 32'(we_o), 32'(e_we));
    chk("idu_valid", 32'(idu_valid_o), 32'(m_live));
    chk("fetch_err", 32'(fetch_err_o), 32'(e_err));
    // Advance the model to the next cycle.
    e_pc   = rd ? rpc : (e_we ? m_addr + 32'd4 : m_pc);
    e_live = rd ? 1'b0 : (e_we ? 1'b1 : (ir ? 1'b0 : m_live));
    if (m_boot) begin
      m_boot  = 1'b0;
      m_offer = 1'b1;
      m_addr  = e_pc;
    end else if (m_offer) begin
      if (rd) m_drop = 1'b1;
      if (ar) begin
        m_offer = 1'b0;
        m_wait  = 1'b1;
      end
    end else if (m_wait) begin
      if (e_hs) begin
        m_wait = 1'b0;
        m_drop = 1'b0;
        if (e_err) begin
          m_halt = 1'b1;
        end else begin
          m_offer = 1'b1;
          m_addr  = e_pc;
        end
      end else if (rd) begin
        m_drop = 1'b1;
      end
    end else if (m_halt && rd) begin
      m_halt  = 1'b0;
      m_offer = 1'b1;
      m_addr  = e_pc;
    end
    m_pc   = e_pc;
    m_live = e_live;
  endtask

  initial begin
    rst = 1'b0;
    do_reset(1'b0);

    // Basic fetch: two sequential addresses, one write each.
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("first_araddr", araddr_o, 32'h8000_0000);
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("first_we", 32'(we_o), 32'd1);
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("second_araddr", araddr_o, 32'h8000_0004);

    // Decode stall: slot full, no handshake until idu_ready rises.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
      chk("stall_rready", 32'(rready_o), 32'd0);
    end
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("stall_release_we", 32'(we_o), 32'd1);

    // Redirect while the address is waiting: address holds, response is dropped.
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h8000_0100);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("redir_ar_hold", araddr_o, 32'h8000_0008);
    step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("killed_we", 32'(we_o), 32'd0);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("redir_araddr", araddr_o, 32'h8000_0100);
    chk("redir_idu_valid", 32'(idu_valid_o), 32'd0);

    // Redirect on the same cycle as the data handshake.
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 32'h8000_0200);
    chk("same_cycle_we", 32'(we_o), 32'd0);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("same_cycle_araddr", araddr_o, 32'h8000_0200);

    // Error response: pulse, then parked until a redirect.
    step(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 32'h0);
    chk("err_pulse", 32'(fetch_err_o), 32'd1);
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("err_arvalid", 32'(arvalid_o), 32'd0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h8000_0300);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("err_resume_arvalid", 32'(arvalid_o), 32'd1);
    chk("err_resume_araddr", araddr_o, 32'h8000_0300);

    // PC wrap at the top of the address space; stale rvalid across reset release.
    do_reset(1'b1);
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("wrap_start", araddr_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("wrap_araddr", araddr_o, 32'h0000_0000);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 1) == 1);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
